// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS instruction encoder / program loader.
// Optional branch/jump statistics outputs are enabled by INSTR_ENC_STATS_EN.
module instr_encoder #(
  parameter int          ADDR_W      = 6,
  parameter int          DEPTH       = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          HALT_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic [31:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
`ifdef INSTR_ENC_STATS_EN
  ,
  output logic [15:0]       br_cnt,
  output logic [15:0]       jmp_cnt
`endif
);

  localparam logic [4:0] M_SLT   = 5'd6;
  localparam logic [4:0] M_JR    = 5'd7;
  localparam logic [4:0] M_LW    = 5'd8;
  localparam logic [4:0] M_SW    = 5'd9;
  localparam logic [4:0] M_BEQ   = 5'd10;
  localparam logic [4:0] M_BNE   = 5'd11;
  localparam logic [4:0] M_J     = 5'd12;
  localparam logic [4:0] M_JAL   = 5'd13;
  localparam logic [4:0] M_ADDI  = 5'd14;
  localparam logic [4:0] M_LUI   = 5'd18;
  localparam logic [4:0] M_SLTIU = 5'd20;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FULL,
    ST_HALT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] wr_ptr;
  logic [31:0]       pc4;
  logic [31:0]       diff;
  logic              br_ok;
  logic              jmp_ok;
  logic              r_type;
  logic              jr;
  logic              i_type;
  logic              br;
  logic              jmp;
  logic [5:0]        r_fn;
  logic [5:0]        i_op;
  logic [31:0]       word;
  logic [1:0]        code;
  logic              accept;
  logic              wr;
  logic              bad;
  logic [ADDR_W:0]   count_inc;
  logic              unused_ok;

  assign wr_ptr = count[ADDR_W-1:0];
  assign pc4    = BASE_ADDR + (32'(wr_ptr) << 2) + 32'd4;
  assign diff   = in_target - pc4;

  // Offset fits in 16 bits iff diff[31:17] is a pure sign extension.
  assign br_ok  = (in_target[1:0] == 2'b00) &&
                  ((&diff[31:17]) || ~(|diff[31:17]));
  assign jmp_ok = (in_target[1:0] == 2'b00) &&
                  (in_target[31:28] == pc4[31:28]);
  assign unused_ok = &{1'b0, diff[1:0]};

  assign r_type = (in_mnem <= M_SLT);
  assign jr     = (in_mnem == M_JR);
  assign i_type = (in_mnem == M_LW) || (in_mnem == M_SW) ||
                  ((in_mnem >= M_ADDI) && (in_mnem <= M_SLTIU));
  assign br     = (in_mnem == M_BEQ) || (in_mnem == M_BNE);
  assign jmp    = (in_mnem == M_J) || (in_mnem == M_JAL);

  always_comb begin
    r_fn = 6'h20;
    case (in_mnem)
      5'd1:    r_fn = 6'h22;
      5'd2:    r_fn = 6'h24;
      5'd3:    r_fn = 6'h25;
      5'd4:    r_fn = 6'h26;
      5'd5:    r_fn = 6'h27;
      5'd6:    r_fn = 6'h2A;
      default: r_fn = 6'h20;
    endcase
  end

  always_comb begin
    i_op = 6'h08;
    case (in_mnem)
      5'd8:    i_op = 6'h23;
      5'd9:    i_op = 6'h2B;
      5'd15:   i_op = 6'h0C;
      5'd16:   i_op = 6'h0D;
      5'd17:   i_op = 6'h0E;
      5'd18:   i_op = 6'h0F;
      5'd19:   i_op = 6'h0A;
      5'd20:   i_op = 6'h0B;
      default: i_op = 6'h08;
    endcase
  end

  always_comb begin
    word = 32'h0;
    code = 2'b00;
    unique case (1'b1)
      r_type: word = {6'h00, in_rs, in_rt, in_rd, 5'd0, r_fn};
      jr:     word = {6'h00, in_rs, 15'd0, 6'h08};
      i_type: word = {i_op,
                      (in_mnem == M_LUI) ? 5'd0 : in_rs,
                      in_rt, in_imm};
      br: begin
        word = {(in_mnem == M_BEQ) ? 6'h04 : 6'h05,
                in_rs, in_rt, diff[17:2]};
        if (!br_ok) code = 2'b10;
      end
      jmp: begin
        word = {(in_mnem == M_J) ? 6'h02 : 6'h03,
                in_target[27:2]};
        if (!jmp_ok) code = 2'b11;
      end
      default: code = 2'b01;
    endcase
  end

  assign in_ready  = rst_n & ~clr & (state == ST_RUN);
  assign accept    = in_valid & in_ready;
  assign bad       = (code != 2'b00);
  assign wr        = accept & ~bad;
  assign count_inc = count + 1'b1;
  assign full      = (count == DEPTH_C);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_RUN: begin
        if (wr && (count_inc == DEPTH_C))
          state_nx = ST_FULL;
        else if (accept && bad && (HALT_ON_ERR != 0))
          state_nx = ST_HALT;
      end
      ST_FULL: state_nx = ST_FULL;
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_RUN;
    endcase
    if (clr) state_nx = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      mem_we <= 1'b0;
      if (clr) begin
        count    <= '0;
        err      <= 1'b0;
        err_code <= 2'b00;
      end else if (wr) begin
        mem_we    <= 1'b1;
        mem_addr  <= wr_ptr;
        mem_wdata <= word;
        count     <= count_inc;
      end else if (accept) begin
        err <= 1'b1;
        // First error code is kept until clr.
        if (!err) err_code <= code;
      end
    end
  end

`ifdef INSTR_ENC_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      br_cnt  <= 16'h0;
      jmp_cnt <= 16'h0;
    end else if (wr) begin
      if (br && (br_cnt != 16'hFFFF))
        br_cnt <= br_cnt + 16'd1;
      if ((jmp || jr) && (jmp_cnt != 16'hFFFF))
        jmp_cnt <= jmp_cnt + 16'd1;
    end
  end
`endif

endmodule
